// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a two-entry instruction buffer.
//
// Issues one word read at a time to instruction memory. Returned words are
// queued with their PC for the decode stage. The next-PC stage can redirect
// fetch at any time. A redirect flushes the buffer. Data from a request that
// was already in flight is dropped when it returns. A misaligned redirect
// target sets a sticky error and halts fetch until reset.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc PC change request from the next-PC stage
//   imem_req, imem_addr   memory read request and byte address (held until ack)
//   imem_ack, imem_rdata  memory response (an ack in the request cycle is allowed)
//   out_valid/ready       handshake for the buffer head toward decode
//   out_pc, out_instr     PC and instruction word at the buffer head
//   pc                    current fetch PC, fed back to the next-PC stage
//   misalign_err          sticky: a misaligned redirect target was received
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] pc,
   output logic        misalign_err
);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALT} state_t;

   localparam logic [1:0] FULL = 2'(DEPTH);

   state_t      state;
   logic [31:0] req_addr;      // address of the request in flight (WAIT/DISCARD)
   logic        halt_pending;  // misaligned redirect seen while discarding

   logic [31:0] buf_pc    [DEPTH];
   logic [31:0] buf_instr [DEPTH];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;

   logic misalign;
   logic take;
   logic push;
   logic pop;

   assign misalign = redirect && (redirect_pc[1:0] != 2'b00);

   // A new request goes out only from IDLE with buffer space. After that it
   // stays up until acked, even across redirects. Reset masks the request so
   // that no request is visible while reset is held.
   assign imem_req  = !reset && ((state == WAIT) || (state == DISCARD) ||
                                 ((state == IDLE) && (count < FULL)));
   assign imem_addr = (state == IDLE) ? pc : req_addr;

   // A redirect in the same cycle drops the returned word and the pop.
   // A word popped in that cycle still counts as consumed by decode.
   assign take = imem_req && imem_ack;
   assign push = take && (state != DISCARD) && !redirect;
   assign pop  = out_valid && out_ready && !redirect;

   assign out_valid = (count != 2'd0);
   assign out_pc    = buf_pc[rd_ptr];
   assign out_instr = buf_instr[rd_ptr];

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         req_addr     <= RESET_PC;
         halt_pending <= 1'b0;
         misalign_err <= 1'b0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         count        <= 2'd0;
         // NOTE: the buffer entries are reset as well, because out_pc and
         // out_instr must read zero after reset. They are two small registers,
         // not a RAM.
         for (int i = 0; i < DEPTH; i++) begin
            buf_pc[i]    <= 32'h0;
            buf_instr[i] <= 32'h0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (imem_req) begin
                  if (imem_ack) begin
                     state <= misalign ? HALT : IDLE;
                  end else begin
                     req_addr     <= pc;
                     state        <= redirect ? DISCARD : WAIT;
                     halt_pending <= misalign;
                  end
               end else if (misalign) begin
                  state <= HALT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  state <= misalign ? HALT : IDLE;
               end else if (redirect) begin
                  state        <= DISCARD;
                  halt_pending <= misalign;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  state        <= (halt_pending || misalign) ? HALT : IDLE;
                  halt_pending <= 1'b0;
               end else if (misalign) begin
                  halt_pending <= 1'b1;
               end
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase

         // Fetch PC: an aligned redirect wins over the sequential increment.
         // A misaligned target is never loaded.
         if (redirect && !misalign) begin
            pc <= redirect_pc;
         end else if (push) begin
            pc <= pc + 32'd4;
         end

         if (misalign) begin
            misalign_err <= 1'b1;
         end

         if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) begin
               buf_pc[wr_ptr]    <= imem_addr;
               buf_instr[wr_ptr] <= imem_rdata;
               wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit with a transaction-level
// reference model (queue of fetched words, outstanding-request bookkeeping).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] pc;
   logic        misalign_err;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .pc(pc), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   // Memory model: content is a fixed function of the address. The ack comes
   // once the request has been waiting ack_delay cycles.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   int ack_delay = 0;
   int wait_cnt  = 0;
   assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
   assign imem_rdata = word_of(imem_addr);

   always @(posedge clk) begin
      if (reset || !imem_req || imem_ack) wait_cnt <= 0;
      else                                 wait_cnt <= wait_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_out, m_discard, m_halt_pend, m_halted, m_err;
   logic [31:0] m_oaddr;
   bit          chk_en = 0;

   function automatic bit exp_req();
      return !reset && (m_out || (!m_halted && m_q.size() < 2));
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_out ? m_oaddr : m_pc;
   endfunction

   always @(posedge clk) begin
      bit req, ack, mis, accept, pop;
      logic [31:0] addr;
      if (reset) begin
         m_q.delete();
         m_pc = 32'h0000_3000;
         m_out = 0; m_discard = 0; m_halt_pend = 0; m_halted = 0; m_err = 0;
         m_oaddr = 32'h0;
      end else begin
         req    = exp_req();
         addr   = exp_addr();
         ack    = req && (wait_cnt >= ack_delay);
         mis    = redirect && (redirect_pc % 4 != 0);
         accept = ack && !m_discard && !redirect;
         pop    = (m_q.size() > 0) && out_ready && !redirect;
         if (ack) begin
            if (m_halt_pend || mis) m_halted = 1;
            m_out = 0; m_discard = 0; m_halt_pend = 0;
         end else if (req) begin
            m_out = 1; m_oaddr = addr;
            if (redirect) m_discard = 1;
            if (mis) m_halt_pend = 1;
         end else if (mis) begin
            m_halted = 1;
         end
         if (redirect) m_q.delete();
         else begin
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back('{pc: addr, instr: word_of(addr)});
         end
         if (redirect && !mis) m_pc = redirect_pc;
         else if (accept)      m_pc = addr + 32'd4;
         if (mis) m_err = 1;
      end
   end

   // Per-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req", 32'(imem_req), 32'(exp_req()));
         if (exp_req()) check("imem_addr", imem_addr, exp_addr());
         check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
         if (m_q.size() > 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
         end
         check("pc", pc, m_pc);
         check("misalign_err", 32'(misalign_err), 32'(m_err));
      end
   end

   // Transaction logs for the literal scenario checks.
   logic [31:0] fetch_log[$];
   logic [31:0] pop_log[$];
   int          fetch_cyc[$];
   int          pop_cyc[$];
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (imem_req && imem_ack) begin
            fetch_log.push_back(imem_addr);
            fetch_cyc.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            pop_log.push_back(out_pc);
            pop_cyc.push_back(cyc);
         end
      end
   end

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect = 1'b0;
      tick();
      chk_en = 1;
      tick();
      reset = 1'b0;
      fetch_log.delete(); pop_log.delete();
      fetch_cyc.delete(); pop_cyc.delete();
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect = 1'b1;
      redirect_pc = target;
      tick();
      redirect = 1'b0;
   endtask

   logic [31:0] targets[4] = '{32'h0000_4000, 32'h0000_5010, 32'hFFFF_FFF8, 32'h0000_0100};
   int          delays[4]  = '{0, 1, 3, 2};

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

      // Streaming with same-cycle ack
      ack_delay = 0; out_ready = 1'b1;
      do_reset();
      #1;
      check("first_req", 32'(imem_req), 32'h1);
      check("first_addr", imem_addr, 32'h0000_3000);
      check("first_valid", 32'(out_valid), 32'h0);
      tick(6);
      check("stream_f0", at(fetch_log, 0), 32'h0000_3000);
      check("stream_f1", at(fetch_log, 1), 32'h0000_3004);
      check("stream_f2", at(fetch_log, 2), 32'h0000_3008);
      check("stream_back2back", 32'(at(fetch_cyc, 1) - at(fetch_cyc, 0)), 32'h1);
      check("stream_p0", at(pop_log, 0), 32'h0000_3000);
      check("stream_p1", at(pop_log, 1), 32'h0000_3004);
      check("stream_lat", 32'(at(pop_cyc, 0) - at(fetch_cyc, 0)), 32'h1);

      // Decode stalled: buffer fills with two words and requests stop
      out_ready = 1'b0;
      do_reset();
      tick(6);
      check("stall_nfetch", 32'(fetch_log.size()), 32'h2);
      #1;
      check("stall_req", 32'(imem_req), 32'h0);
      check("stall_head", out_pc, 32'h0000_3000);
      out_ready = 1'b1;
      tick(4);
      check("resume_f2", at(fetch_log, 2), 32'h0000_3008);
      check("resume_p0", at(pop_log, 0), 32'h0000_3000);
      check("resume_p1", at(pop_log, 1), 32'h0000_3004);

      // Redirect during a slow request: old address held, its data dropped
      ack_delay = 3;
      do_reset();
      tick();
      pulse_redirect(32'h0000_4000);
      #1;
      check("disc_req", 32'(imem_req), 32'h1);
      check("disc_addr", imem_addr, 32'h0000_3000);
      check("disc_pc", pc, 32'h0000_4000);
      tick(12);
      check("disc_f0", at(fetch_log, 0), 32'h0000_3000);
      check("disc_f1", at(fetch_log, 1), 32'h0000_4000);
      check("disc_p0", at(pop_log, 0), 32'h0000_4000);

      // Redirect coincident with an ack: that word never reaches decode
      ack_delay = 0;
      do_reset();
      tick();
      pulse_redirect(32'h0000_5000);
      tick(4);
      check("coin_f2", at(fetch_log, 2), 32'h0000_5000);
      check("coin_p0", at(pop_log, 0), 32'h0000_3000);
      check("coin_p1", at(pop_log, 1), 32'h0000_5000);
      begin
         int hits = 0;
         foreach (pop_log[i]) if (pop_log[i] == 32'h0000_3004) hits++;
         check("coin_no3004", 32'(hits), 32'h0);
      end

      // PC wrap at the top of the address space
      do_reset();
      pulse_redirect(32'hFFFF_FFFC);
      tick(5);
      check("wrap_f1", at(fetch_log, 1), 32'hFFFF_FFFC);
      check("wrap_f2", at(fetch_log, 2), 32'h0000_0000);
      check("wrap_p0", at(pop_log, 0), 32'hFFFF_FFFC);
      check("wrap_p1", at(pop_log, 1), 32'h0000_0000);

      // Misaligned redirect from IDLE halts immediately
      do_reset();
      pulse_redirect(32'h0000_3002);
      #1;
      check("mis_err", 32'(misalign_err), 32'h1);
      check("mis_valid", 32'(out_valid), 32'h0);
      check("mis_req", 32'(imem_req), 32'h0);
      tick(5);
      check("mis_req_late", 32'(imem_req), 32'h0);
      check("mis_nfetch", 32'(fetch_log.size()), 32'h1);

      // Misaligned redirect while waiting: discard first, then halt
      ack_delay = 2;
      do_reset();
      #1;
      check("mis_err_cleared", 32'(misalign_err), 32'h0);
      tick();
      pulse_redirect(32'h0000_3006);
      #1;
      check("mis2_req", 32'(imem_req), 32'h1);
      check("mis2_addr", imem_addr, 32'h0000_3000);
      tick(5);
      check("mis2_req_late", 32'(imem_req), 32'h0);
      check("mis2_nfetch", 32'(fetch_log.size()), 32'h1);

      // Reset wins over a redirect and an ack in the same cycle
      ack_delay = 0;
      do_reset();
      tick(3);
      reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_8000;
      tick();
      reset = 1'b0; redirect = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_addr", imem_addr, 32'h0000_3000);

      // Mixed traffic: model-checked every cycle
      do_reset();
      for (int i = 0; i < 300; i++) begin
         ack_delay   = delays[(i / 40) % 4];
         out_ready   = 1'($urandom_range(0, 1));
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = targets[$urandom_range(0, 3)];
         tick();
      end
      redirect = 1'b0;
      out_ready = 1'b1;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
